// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Shares one 32-bit memory bus between instruction fetch (IF) and load/store (LS).
//   Handles arbitration, byte-enable and write-data lane placement, load extension,
//   the ack wait with timeout, and misalignment errors that never reach the bus.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   if_req/if_addr              fetch request (held until if_valid)
//   if_valid/if_data/if_err     fetch completion pulse, word, error flag
//   ls_req/ls_type/ls_addr/
//   ls_wdata                    load/store request (held until ls_valid)
//   ls_valid/ls_rdata/ls_err    LS completion pulse, extended load data, error flag
//   mem_req/mem_addr/mem_we/
//   mem_byte_en/mem_wdata       memory bus request side
//   mem_rdata/mem_ack           memory bus response side
//   busy                        sequencer not idle
//
// state  | meaning
// IDLE   | bus free, arbitrating between if_req and ls_req
// BUS_IF | fetch on the bus, waiting for mem_ack or timeout
// BUS_LS | load/store on the bus, waiting for mem_ack or timeout
// ERR_IF | misaligned fetch, error pulse being presented
// ERR_LS | misaligned load/store, error pulse being presented

module mem_access_sequencer #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_data,
  output logic        if_err,
  input  logic        ls_req,
  input  logic [2:0]  ls_type,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [2:0] LD32  = 3'd0;
  localparam logic [2:0] LDU16 = 3'd1;
  localparam logic [2:0] LDS16 = 3'd2;
  localparam logic [2:0] LDU8  = 3'd3;
  localparam logic [2:0] LDS8  = 3'd4;
  localparam logic [2:0] ST32  = 3'd5;
  localparam logic [2:0] ST16  = 3'd6;

  typedef enum logic [2:0] {IDLE, BUS_IF, BUS_LS, ERR_IF, ERR_LS} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] to_cnt;
  logic [2:0]    acc_type;
  logic [1:0]    acc_off;

  logic        grant_ls, grant_if;
  logic        ls_is32, ls_is16, ls_store, ls_mis, if_mis;
  logic [3:0]  ls_be;
  logic [31:0] ls_wlane;
  logic        timed_out;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  // LS wins ties until IF has been passed over STARVE_LIMIT times in a row.
  assign grant_ls = ls_req && !(if_req && (starve_cnt == SW'(STARVE_LIMIT)));
  assign grant_if = if_req && !grant_ls;

  assign ls_is32  = (ls_type == LD32) || (ls_type == ST32);
  assign ls_is16  = (ls_type == LDU16) || (ls_type == LDS16) || (ls_type == ST16);
  assign ls_store = (ls_type >= ST32);
  assign ls_mis   = (ls_is32 && (ls_addr[1:0] != 2'b00)) || (ls_is16 && ls_addr[0]);
  assign if_mis   = (if_addr[1:0] != 2'b00);

  always_comb begin
    ls_be    = 4'b0001 << ls_addr[1:0];
    ls_wlane = {4{ls_wdata[7:0]}};
    if (ls_is32) begin
      ls_be    = 4'b1111;
      ls_wlane = ls_wdata;
    end else if (ls_is16) begin
      ls_be    = 4'b0011 << ls_addr[1:0];
      ls_wlane = {2{ls_wdata[15:0]}};
    end
  end

  // Last waiting cycle: an ack here still wins over the timeout.
  assign timed_out = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign rd_byte = mem_rdata[8*acc_off +: 8];
  assign rd_half = acc_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_ext = 32'h0;
    case (acc_type)
      LD32:    load_ext = mem_rdata;
      LDU16:   load_ext = {16'h0, rd_half};
      LDS16:   load_ext = {{16{rd_half[15]}}, rd_half};
      LDU8:    load_ext = {24'h0, rd_byte};
      LDS8:    load_ext = {{24{rd_byte[7]}}, rd_byte};
      default: load_ext = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_ls)      state_nxt = ls_mis ? ERR_LS : BUS_LS;
        else if (grant_if) state_nxt = if_mis ? ERR_IF : BUS_IF;
      end
      BUS_IF, BUS_LS: begin
        if (mem_ack || timed_out) state_nxt = IDLE;
      end
      ERR_IF, ERR_LS: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_req is decoded from the state register so reset drops it immediately.
  assign mem_req = (state == BUS_IF) || (state == BUS_LS);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt  <= '0;
      to_cnt      <= '0;
      acc_type    <= 3'd0;
      acc_off     <= 2'd0;
      mem_addr    <= 32'h0;
      mem_we      <= 1'b0;
      mem_byte_en <= 4'h0;
      mem_wdata   <= 32'h0;
      if_valid    <= 1'b0;
      if_data     <= 32'h0;
      if_err      <= 1'b0;
      ls_valid    <= 1'b0;
      ls_rdata    <= 32'h0;
      ls_err      <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      if_data  <= 32'h0;
      if_err   <= 1'b0;
      ls_valid <= 1'b0;
      ls_rdata <= 32'h0;
      ls_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ls) begin
            if (if_req && (starve_cnt != SW'(STARVE_LIMIT)))
              starve_cnt <= starve_cnt + 1'b1;
            acc_type <= ls_type;
            acc_off  <= ls_addr[1:0];
            if (ls_mis) begin
              ls_valid <= 1'b1;
              ls_err   <= 1'b1;
            end else begin
              to_cnt      <= '0;
              mem_addr    <= {ls_addr[31:2], 2'b00};
              mem_we      <= ls_store;
              mem_byte_en <= ls_be;
              mem_wdata   <= ls_store ? ls_wlane : 32'h0;
            end
          end else if (grant_if) begin
            starve_cnt <= '0;
            if (if_mis) begin
              if_valid <= 1'b1;
              if_err   <= 1'b1;
            end else begin
              to_cnt      <= '0;
              mem_addr    <= {if_addr[31:2], 2'b00};
              mem_we      <= 1'b0;
              mem_byte_en <= 4'b1111;
              mem_wdata   <= 32'h0;
            end
          end
        end
        BUS_IF: begin
          if (mem_ack) begin
            if_valid <= 1'b1;
            if_data  <= mem_rdata;
          end else if (timed_out) begin
            if_valid <= 1'b1;
            if_err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        BUS_LS: begin
          if (mem_ack) begin
            ls_valid <= 1'b1;
            ls_rdata <= load_ext;
          end else if (timed_out) begin
            ls_valid <= 1'b1;
            ls_err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
